grid_path_walker: RTL and testbench

- Parametrised successor of the team's 3x3 path-sum block.
- Reads a move program from a synchronous-read memory: word 0 is the length N, words 1..N are move codes.
- Walks a ROWS x COLS grid of programmable signed cell weights and accumulates the path sum, with wrap or saturate arithmetic.
- Reports result, final position and blocked-move count. Sits between the program RAM and the host controller.

---
 rtl/grid_path_walker_pkg.sv | 22 ++
 rtl/grid_path_walker_if.sv | 40 ++++
 rtl/grid_path_walker_sat_add.sv | 23 ++
 rtl/grid_path_walker.sv | 162 ++++++++++++++++
 tb/tb_grid_path_walker.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_path_walker_pkg.sv
// Shared definitions for the grid path walker: move codes, FSM states and
// a width helper that keeps single-row/column grids at one index bit.
package grid_walk_pkg;

    localparam int MV_RIGHT = 1;
    localparam int MV_UP    = 2;
    localparam int MV_LEFT  = 3;
    localparam int MV_DOWN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_REQ,
        ST_LEN_WAIT,
        ST_WALK,
        ST_DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/grid_path_walker_if.sv
// Host/program-memory bus of the grid path walker; master is the walker side.
interface grid_path_walker_if
    import grid_walk_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int DW   = 5,
    parameter int AW   = 5,
    parameter int WW   = 5,
    parameter int SW   = 8
);
    localparam int IW = idx_w(ROWS * COLS);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    logic                 start;
    logic [DW-1:0]        data;
    logic                 en;
    logic [AW-1:0]        addr;
    logic                 wcfg_we;
    logic [IW-1:0]        wcfg_idx;
    logic signed [WW-1:0] wcfg_val;
    logic                 busy;
    logic                 fin;
    logic signed [SW-1:0] result;
    logic [RW-1:0]        pos_row;
    logic [CW-1:0]        pos_col;
    logic [AW-1:0]        bumps;

    modport master (
        input  start, data, wcfg_we, wcfg_idx, wcfg_val,
        output en, addr, busy, fin, result, pos_row, pos_col, bumps
    );

    modport slave (
        output start, data, wcfg_we, wcfg_idx, wcfg_val,
        input  en, addr, busy, fin, result, pos_row, pos_col, bumps
    );

endinterface

// File: rtl/grid_path_walker_sat_add.sv
// Signed SW-bit adder that either wraps or clamps to the signed range.
module gw_sat_add #(
    parameter int SW  = 8,
    parameter int SAT = 0
) (
    input  logic signed [SW-1:0] i_a,
    input  logic signed [SW-1:0] i_b,
    output logic signed [SW-1:0] o_y
);

    function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] a,
                                                      input logic signed [SW-1:0] b);
        logic signed [SW:0] s;
        s = {a[SW-1], a} + {b[SW-1], b};
        // Overflow shows up as disagreement between the guard bit and the sign bit.
        if ((SAT != 0) && (s[SW] != s[SW-1]))
            return s[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        return s[SW-1:0];
    endfunction

    assign o_y = sat_add(i_a, i_b);

endmodule

// File: rtl/grid_path_walker.sv
// Grid path walker: fetches a move program from synchronous-read memory and
// accumulates the signed cell weights along the walked path.
module grid_path_walker
    import grid_walk_pkg::*;
#(
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int DW      = 5,
    parameter int AW      = 5,
    parameter int WW      = 5,
    parameter int SW      = 8,
    parameter int START_R = 1,
    parameter int START_C = 1,
    parameter int SAT     = 0
) (
    input  logic               clk,
    input  logic               rst,
    grid_path_walker_if.master bus
);
    localparam int NCELL   = ROWS * COLS;
    localparam int IW      = idx_w(NCELL);
    localparam int RW      = idx_w(ROWS);
    localparam int CW      = idx_w(COLS);
    localparam int LEN_MAX = (1 << AW) - 1;

    state_t               r_state, w_next;
    logic                 r_en, r_busy, r_fin, r_dv;
    logic [AW-1:0]        r_addr, r_len, r_bumps, w_len;
    logic signed [SW-1:0] r_acc, r_result, w_wext, w_sum;
    logic [RW-1:0]        r_row, w_row;
    logic [CW-1:0]        r_col, w_col;
    logic signed [WW-1:0] r_wgt [NCELL];
    logic [DW-1:0]        w_data;
    logic [IW-1:0]        w_cell;
    logic                 w_blocked, w_load_start, w_take_len, w_issue, w_consume, w_finish;

    assign w_data = bus.data;
    assign w_len  = (int'(w_data) > LEN_MAX) ? AW'(LEN_MAX) : AW'(w_data);

    // Candidate position for the move word on the data bus; off-grid moves stay put.
    always_comb begin
        w_row     = r_row;
        w_col     = r_col;
        w_blocked = 1'b0;
        case (int'(w_data))
            MV_RIGHT: if (int'(r_col) + 1 >= COLS) w_blocked = 1'b1;
                      else w_col = r_col + CW'(1);
            MV_UP:    if (r_row == '0) w_blocked = 1'b1;
                      else w_row = r_row - RW'(1);
            MV_LEFT:  if (r_col == '0) w_blocked = 1'b1;
                      else w_col = r_col - CW'(1);
            MV_DOWN:  if (int'(r_row) + 1 >= ROWS) w_blocked = 1'b1;
                      else w_row = r_row + RW'(1);
            default:  ;
        endcase
    end

    assign w_cell = IW'(int'(w_row) * COLS + int'(w_col));
    assign w_wext = SW'(r_wgt[w_cell]);

    gw_sat_add #(.SW(SW), .SAT(SAT)) u_add (
        .i_a (r_acc),
        .i_b (w_wext),
        .o_y (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load_start = 1'b0;
        w_take_len   = 1'b0;
        w_issue      = 1'b0;
        w_consume    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) begin
                w_next       = ST_LEN_REQ;
                w_load_start = 1'b1;
            end
            ST_LEN_REQ: w_next = ST_LEN_WAIT;
            ST_LEN_WAIT: begin
                w_take_len = 1'b1;
                if (w_len == '0) begin
                    w_next   = ST_IDLE;
                    w_finish = 1'b1;
                end else begin
                    w_next  = ST_WALK;
                    w_issue = 1'b1;
                end
            end
            // Data for the address issued last cycle is on the bus whenever r_dv is set.
            ST_WALK: begin
                w_consume = r_dv;
                if (r_addr == r_len) w_next = ST_DONE;
                else                 w_issue = 1'b1;
            end
            ST_DONE: begin
                w_consume = r_dv;
                w_finish  = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_dv     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_bumps  <= '0;
            r_row    <= RW'(START_R);
            r_col    <= CW'(START_C);
            for (int i = 0; i < NCELL; i++) r_wgt[i] <= '0;
        end else begin
            r_en  <= w_load_start | w_issue;
            r_dv  <= r_en;
            r_fin <= w_finish;
            if (w_load_start) begin
                r_addr  <= '0;
                r_busy  <= 1'b1;
                r_acc   <= '0;
                r_bumps <= '0;
                r_row   <= RW'(START_R);
                r_col   <= CW'(START_C);
            end
            if (w_take_len) r_len  <= w_len;
            if (w_issue)    r_addr <= r_addr + AW'(1);
            if (w_consume) begin
                r_row <= w_row;
                r_col <= w_col;
                r_acc <= w_sum;
                if (w_blocked && (r_bumps != '1)) r_bumps <= r_bumps + AW'(1);
            end
            if (w_finish) begin
                r_busy   <= 1'b0;
                r_result <= w_consume ? w_sum : r_acc;
            end
            if (!r_busy && bus.wcfg_we && (int'(bus.wcfg_idx) < NCELL))
                r_wgt[bus.wcfg_idx] <= bus.wcfg_val;
        end
    end

    assign bus.en      = r_en;
    assign bus.addr    = r_addr;
    assign bus.busy    = r_busy;
    assign bus.fin     = r_fin;
    assign bus.result  = r_result;
    assign bus.pos_row = r_row;
    assign bus.pos_col = r_col;
    assign bus.bumps   = r_bumps;

endmodule

// File: tb/tb_grid_path_walker.sv
// Directed bench for grid_path_walker: 3x3/SW=8 walks plus SW=4 wrap and saturate variants.
module tb_grid_path_walker;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   fc;
    int   wtab [9] = '{-2, -1, 2, -1, 0, 1, 2, 1, -2};
    logic [4:0] mem  [32];
    logic [4:0] smem [32];

    grid_path_walker_if #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(8)) m ();
    grid_path_walker_if #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(4)) b0 ();
    grid_path_walker_if #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(4)) b1 ();

    grid_path_walker #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(8),
                       .START_R(1), .START_C(1), .SAT(0)) dut (.clk(clk), .rst(rst), .bus(m));
    grid_path_walker #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(4),
                       .START_R(1), .START_C(1), .SAT(0)) dut_wrap (.clk(clk), .rst(rst), .bus(b0));
    grid_path_walker #(.ROWS(3), .COLS(3), .DW(5), .AW(5), .WW(5), .SW(4),
                       .START_R(1), .START_C(1), .SAT(1)) dut_sat (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memories
    always @(posedge clk or posedge rst) begin
        if (rst) m.data <= '0;
        else if (m.en) m.data <= mem[m.addr];
    end
    always @(posedge clk or posedge rst) begin
        if (rst) b0.data <= '0;
        else if (b0.en) b0.data <= smem[b0.addr];
    end
    always @(posedge clk or posedge rst) begin
        if (rst) b1.data <= '0;
        else if (b1.en) b1.data <= smem[b1.addr];
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(input int from, output int cyc);
        cyc = from;
        while (m.fin !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_main(output int cyc);
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        wait_fin(1, cyc);
    endtask

    task automatic prog_main();
        for (int i = 0; i < 9; i++) begin
            m.wcfg_we  = 1'b1;
            m.wcfg_idx = 4'(i);
            m.wcfg_val = 5'(wtab[i]);
            step();
        end
        m.wcfg_we = 1'b0;
    endtask

    task automatic set_prog(input int n, input int c1, input int c2, input int c3);
        mem[0] = 5'(n);
        mem[1] = 5'(c1);
        mem[2] = 5'(c2);
        mem[3] = 5'(c3);
    endtask

    initial begin
        rst = 1'b0;
        m.start = 1'b0;  m.wcfg_we = 1'b0;  m.wcfg_idx = '0;  m.wcfg_val = '0;
        b0.start = 1'b0; b0.wcfg_we = 1'b0; b0.wcfg_idx = '0; b0.wcfg_val = '0;
        b1.start = 1'b0; b1.wcfg_we = 1'b0; b1.wcfg_idx = '0; b1.wcfg_val = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            smem[i] = '0;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_en",     32'(m.en), 0);
        chk("rst_addr",   32'(m.addr), 0);
        chk("rst_busy",   32'(m.busy), 0);
        chk("rst_fin",    32'(m.fin), 0);
        chk("rst_result", 32'(m.result), 0);
        chk("rst_bumps",  32'(m.bumps), 0);
        chk("rst_row",    32'(m.pos_row), 1);
        chk("rst_col",    32'(m.pos_col), 1);
        step();
        step();
        rst = 1'b0;
        step();
        prog_main();

        // Scenario 1: RIGHT, UP, LEFT with per-cycle timeline
        set_prog(3, 1, 2, 3);
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        chk("s1_c1_en",   32'(m.en), 1);
        chk("s1_c1_addr", 32'(m.addr), 0);
        chk("s1_c1_busy", 32'(m.busy), 1);
        step();
        chk("s1_c2_en",   32'(m.en), 0);
        step();
        chk("s1_c3_en",   32'(m.en), 1);
        chk("s1_c3_addr", 32'(m.addr), 1);
        step();
        step();
        chk("s1_c5_addr", 32'(m.addr), 3);
        step();
        chk("s1_c6_en",   32'(m.en), 0);
        chk("s1_c6_fin",  32'(m.fin), 0);
        chk("s1_c6_busy", 32'(m.busy), 1);
        step();
        chk("s1_c7_fin",  32'(m.fin), 1);
        chk("s1_c7_busy", 32'(m.busy), 0);
        chk("s1_result",  32'(m.result), 2);
        chk("s1_row",     32'(m.pos_row), 0);
        chk("s1_col",     32'(m.pos_col), 1);
        chk("s1_bumps",   32'(m.bumps), 0);
        step();
        chk("s1_c8_fin",  32'(m.fin), 0);
        chk("s1_c8_hold", 32'(m.result), 2);

        // Scenario 3: empty program
        set_prog(0, 0, 0, 0);
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        chk("s3_c1_en",  32'(m.en), 1);
        step();
        chk("s3_c2_en",  32'(m.en), 0);
        chk("s3_c2_fin", 32'(m.fin), 0);
        step();
        chk("s3_c3_fin",    32'(m.fin), 1);
        chk("s3_c3_en",     32'(m.en), 0);
        chk("s3_c3_busy",   32'(m.busy), 0);
        chk("s3_result",    32'(m.result), 0);
        chk("s3_row",       32'(m.pos_row), 1);
        chk("s3_col",       32'(m.pos_col), 1);
        chk("s3_bumps",     32'(m.bumps), 0);
        step();

        // Scenario 2: UP x3 runs into the top edge twice
        set_prog(3, 2, 2, 2);
        run_main(fc);
        chk("s2_fin_cycle", fc, 7);
        chk("s2_result",    32'(m.result), -3);
        chk("s2_bumps",     32'(m.bumps), 2);
        chk("s2_row",       32'(m.pos_row), 0);
        chk("s2_col",       32'(m.pos_col), 1);
        step();

        // Scenario 4: asynchronous reset in C5
        set_prog(3, 1, 2, 3);
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("s4_en",     32'(m.en), 0);
        chk("s4_addr",   32'(m.addr), 0);
        chk("s4_busy",   32'(m.busy), 0);
        chk("s4_fin",    32'(m.fin), 0);
        chk("s4_result", 32'(m.result), 0);
        chk("s4_bumps",  32'(m.bumps), 0);
        chk("s4_row",    32'(m.pos_row), 1);
        chk("s4_col",    32'(m.pos_col), 1);
        step();
        rst = 1'b0;
        step();
        run_main(fc);
        chk("s4_cleared_wgt", 32'(m.result), 0);
        step();
        prog_main();
        run_main(fc);
        chk("s4_rerun_cycle",  fc, 7);
        chk("s4_rerun_result", 32'(m.result), 2);
        step();

        // Scenario 5: start and weight writes while busy are ignored
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        step();
        m.start    = 1'b1;
        m.wcfg_we  = 1'b1;
        m.wcfg_idx = 4'd5;
        m.wcfg_val = 5'(-8);
        step();
        m.start   = 1'b0;
        m.wcfg_we = 1'b0;
        wait_fin(3, fc);
        chk("s5_fin_cycle", fc, 7);
        chk("s5_result",    32'(m.result), 2);
        step();
        chk("s5_no_restart_busy", 32'(m.busy), 0);
        chk("s5_no_restart_en",   32'(m.en), 0);
        run_main(fc);
        chk("s5_wgt_kept", 32'(m.result), 2);
        step();

        // start held high through fin launches the next run at once
        m.start = 1'b1;
        step();
        wait_fin(1, fc);
        chk("held_fin_cycle", fc, 7);
        step();
        chk("held_busy", 32'(m.busy), 1);
        chk("held_en",   32'(m.en), 1);
        chk("held_addr", 32'(m.addr), 0);
        m.start = 1'b0;
        wait_fin(1, fc);
        chk("held_result", 32'(m.result), 2);
        step();

        // Scenario 6: SW=4, centre weight 3, four stay moves
        smem[0] = 5'd4;
        b0.wcfg_we = 1'b1; b0.wcfg_idx = 4'd4; b0.wcfg_val = 5'd3;
        b1.wcfg_we = 1'b1; b1.wcfg_idx = 4'd4; b1.wcfg_val = 5'd3;
        step();
        b0.wcfg_we = 1'b0;
        b1.wcfg_we = 1'b0;
        b0.start = 1'b1;
        b1.start = 1'b1;
        step();
        b0.start = 1'b0;
        b1.start = 1'b0;
        fc = 1;
        while (b0.fin !== 1'b1 && fc < 60) begin
            step();
            fc++;
        end
        chk("s6_fin_cycle",  fc, 8);
        chk("s6_sat_fin",    32'(b1.fin), 1);
        chk("s6_wrap_result", 32'(b0.result), -4);
        chk("s6_sat_result",  32'(b1.result), 7);
        chk("s6_row",         32'(b1.pos_row), 1);
        chk("s6_bumps",       32'(b1.bumps), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
